// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Receiver-side and register-side signal bundle for uart_rx_fifo.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic          b_tick;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          flush;
    logic          ovr_clr;
    logic [AW:0]   thresh;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          overrun;
    logic          irq_thresh;
    logic          irq_timeout;

    modport master (
        output b_tick, rx_done, rx_data, rd_en, flush, ovr_clr, thresh,
        input  rd_data, level, empty, full, overrun, irq_thresh, irq_timeout
    );

    modport slave (
        input  b_tick, rx_done, rx_data, rd_en, flush, ovr_clr, thresh,
        output rd_data, level, empty, full, overrun, irq_thresh, irq_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive FIFO with level, overrun, threshold and timeout irqs.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int TO_TICKS = 160
) (
    input  wire             clk,
    input  wire             rst,
    uart_rx_fifo_if.slave   bus
);
    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [15:0]   C_TO      = 16'(TO_TICKS);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   to_cnt_q, to_cnt_d;
    logic          irq_to_q, irq_to_d;

    logic w_empty, w_full, w_wr_acc, w_rd_acc, w_ovr_set;

    assign w_empty   = (level_q == '0);
    assign w_full    = (level_q == C_DEPTH);
    // A full FIFO still takes a byte when a pop frees its slot the same cycle.
    assign w_wr_acc  = bus.rx_done && (!w_full || bus.rd_en);
    assign w_rd_acc  = bus.rd_en && !w_empty;
    assign w_ovr_set = bus.rx_done && w_full && !bus.rd_en;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        to_cnt_d  = to_cnt_q;
        irq_to_d  = irq_to_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            to_cnt_d = '0;
            irq_to_d = 1'b0;
            if (bus.ovr_clr) begin
                overrun_d = 1'b0;
            end
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                level_d = level_q + C_LVL_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                level_d = level_q - C_LVL_ONE;
            end
            if (w_ovr_set) begin
                overrun_d = 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_d = 1'b0;
            end
            // Idle timer only runs while data sits untouched in the FIFO.
            if (w_wr_acc || w_rd_acc) begin
                to_cnt_d = '0;
                irq_to_d = 1'b0;
            end else if (w_empty) begin
                to_cnt_d = '0;
            end else if (bus.b_tick && (to_cnt_q != C_TO)) begin
                to_cnt_d = to_cnt_q + 16'd1;
                if (to_cnt_d == C_TO) begin
                    irq_to_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            to_cnt_q  <= '0;
            irq_to_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            to_cnt_q  <= to_cnt_d;
            irq_to_q  <= irq_to_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && w_wr_acc) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rd_data     = mem_q[rd_ptr_q];
    assign bus.level       = level_q;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.overrun     = overrun_q;
    assign bus.irq_timeout = irq_to_q;
    assign bus.irq_thresh  = (bus.thresh != '0) && (level_q >= bus.thresh);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed plus randomized bench for uart_rx_fifo with a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.AW(AW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .TO_TICKS(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Behavioural model: contents as a queue, flags as plain bits.
    logic [7:0] mq [$];
    bit m_ovr = 1'b0;
    bit m_irq = 1'b0;
    int m_cnt = 0;
    bit m_wr, m_rd, m_full, m_empty;
    logic [7:0] m_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovr = 1'b0;
            m_irq = 1'b0;
            m_cnt = 0;
        end else if (bus.flush) begin
            mq.delete();
            m_cnt = 0;
            m_irq = 1'b0;
            if (bus.ovr_clr) m_ovr = 1'b0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            m_rd = bus.rd_en && !m_empty;
            m_wr = bus.rx_done && (!m_full || bus.rd_en);
            if (m_rd) m_pop = mq.pop_front();
            if (m_wr) mq.push_back(bus.rx_data);
            if (bus.rx_done && m_full && !bus.rd_en) m_ovr = 1'b1;
            else if (bus.ovr_clr) m_ovr = 1'b0;
            if (m_wr || m_rd) begin
                m_cnt = 0;
                m_irq = 1'b0;
            end else if (m_empty) begin
                m_cnt = 0;
            end else if (bus.b_tick && m_cnt < TO) begin
                m_cnt++;
                if (m_cnt == TO) m_irq = 1'b1;
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (checking) begin
            check("level", 32'(bus.level), 32'(mq.size()));
            check("empty", 32'(bus.empty), 32'(mq.size() == 0));
            check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
            check("irq_timeout", 32'(bus.irq_timeout), 32'(m_irq));
            check("irq_thresh", 32'(bus.irq_thresh),
                  32'((bus.thresh != 0) && (mq.size() >= int'(bus.thresh))));
            if (mq.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(mq[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rx_done = 1'b0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.ovr_clr = 1'b0;
        bus.b_tick  = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        step();
        bus.rx_done = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        logic [7:0] exp3 [3];
        int wr_p, rd_p;
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        idle_inputs();
        bus.rx_data = 8'h00;
        bus.thresh  = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        checking = 1'b1;
        check("reset level", 32'(bus.level), 0);
        check("reset empty", 32'(bus.empty), 1);
        check("reset full", 32'(bus.full), 0);
        check("reset overrun", 32'(bus.overrun), 0);
        check("reset irq_timeout", 32'(bus.irq_timeout), 0);

        // Basic three-byte write and drain
        for (int i = 0; i < 3; i++) push(exp3[i]);
        check("t1 level", 32'(bus.level), 3);
        check("t1 model level", 32'(mq.size()), 3);
        check("t1 head", 32'(bus.rd_data), 32'h11);
        for (int i = 0; i < 3; i++) begin
            check("t1 drain", 32'(bus.rd_data), 32'(exp3[i]));
            pop();
        end
        check("t1 empty", 32'(bus.empty), 1);
        check("t1 level0", 32'(bus.level), 0);

        // Fill then overflow
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        check("t2 full", 32'(bus.full), 1);
        check("t2 overrun", 32'(bus.overrun), 1);
        check("t2 level", 32'(bus.level), 16);
        for (int i = 0; i < 16; i++) begin
            check("t2 drain", 32'(bus.rd_data), 32'(i));
            pop();
        end
        check("t2 empty", 32'(bus.empty), 1);
        bus.ovr_clr = 1'b1; step(); bus.ovr_clr = 1'b0;
        check("t2 ovr_clr", 32'(bus.overrun), 0);

        // Simultaneous write and read on a full FIFO
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        bus.rx_done = 1'b1; bus.rx_data = 8'h55; bus.rd_en = 1'b1;
        step();
        bus.rx_done = 1'b0; bus.rd_en = 1'b0;
        check("t3 level", 32'(bus.level), 16);
        check("t3 overrun", 32'(bus.overrun), 0);
        check("t3 head", 32'(bus.rd_data), 32'h81);
        for (int i = 0; i < 15; i++) pop();
        check("t3 last", 32'(bus.rd_data), 32'h55);
        pop();
        check("t3 empty", 32'(bus.empty), 1);

        // Pointer wrap
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h30 + i));
            check("t4 level1", 32'(bus.level), 1);
            check("t4 data", 32'(bus.rd_data), 32'(8'(8'h30 + i)));
            pop();
            check("t4 level0", 32'(bus.level), 0);
        end
        check("t4 overrun", 32'(bus.overrun), 0);

        // Threshold interrupt
        bus.thresh = 5'd4;
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        check("t5 below", 32'(bus.irq_thresh), 0);
        push(8'hC3);
        check("t5 at", 32'(bus.irq_thresh), 1);
        pop();
        check("t5 after pop", 32'(bus.irq_thresh), 0);
        pulse_flush();
        bus.thresh = '0;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t5 disabled", 32'(bus.irq_thresh), 0);
        bus.thresh = 5'd20;
        step();
        check("t5 above depth", 32'(bus.irq_thresh), 0);
        bus.thresh = '0;
        pulse_flush();

        // Character timeout
        push(8'h77);
        bus.b_tick = 1'b1;
        repeat (TO - 1) step();
        check("t6 before", 32'(bus.irq_timeout), 0);
        step();
        check("t6 fired", 32'(bus.irq_timeout), 1);
        bus.b_tick = 1'b0;
        pop();
        check("t6 cleared", 32'(bus.irq_timeout), 0);
        for (int i = 0; i < 17; i++) push(8'(i));
        bus.flush = 1'b1; bus.rx_done = 1'b1; bus.rx_data = 8'hEE;
        step();
        bus.flush = 1'b0; bus.rx_done = 1'b0;
        check("t6 flush level", 32'(bus.level), 0);
        check("t6 flush overrun", 32'(bus.overrun), 1);
        bus.ovr_clr = 1'b1; step(); bus.ovr_clr = 1'b0;

        // Randomized traffic with biased fill direction per block
        wr_p = 50; rd_p = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) begin
                wr_p = $urandom_range(20, 90);
                rd_p = $urandom_range(20, 90);
                bus.thresh = 5'($urandom_range(0, 20));
            end
            if (c % 700 == 350) begin
                idle_inputs();
                bus.b_tick = 1'b1;
                repeat (TO + 20) step();
            end
            bus.rx_done = ($urandom_range(0, 99) < wr_p);
            bus.rx_data = 8'($urandom);
            bus.rd_en   = ($urandom_range(0, 99) < rd_p);
            bus.flush   = ($urandom_range(0, 127) == 0);
            bus.ovr_clr = ($urandom_range(0, 15) == 0);
            bus.b_tick  = ($urandom_range(0, 1) == 1);
            step();
        end
        idle_inputs();
        step();
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART receiver. It captures each byte the receiver flags with its one-cycle done strobe and stores it in a circular FIFO. The CPU-facing peripheral register interface drains the FIFO. The block also reports fill level, a sticky overrun flag, a fill-threshold interrupt and a character-timeout interrupt, so software can service partial bursts.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 4
AW, 4, pointer width; must equal log2(DEPTH)
TO_TICKS, 160, b_tick count with no FIFO activity before irq_timeout asserts (4 chars at 4 ticks/bit, 10 bits/char); range 1..65535

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
b_tick  in  1  baud oversample tick, same source as the receiver's tick
rx_done  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
rd_en  in  1  pop request; one entry per cycle while high and not empty
rd_data  out  8  head entry; valid while empty=0 (first-word fall-through)
flush  in  1  discard all contents
ovr_clr  in  1  clear overrun flag
thresh  in  AW+1  interrupt threshold; 0 disables irq_thresh
level  out  AW+1  current entry count, 0..DEPTH
empty  out  1  level==0
full  out  1  level==DEPTH
overrun  out  1  sticky: byte dropped because FIFO was full
irq_thresh  out  1  level>=thresh and thresh!=0
irq_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (rst high at clk edge) clears pointers, level=0, empty=1, full=0, overrun=0, irq_timeout=0, timeout counter=0. Storage contents are don't-care. rd_data is don't-care while empty.
- Storage: DEPTH x 8 array. Write pointer and read pointer are AW bits and wrap modulo DEPTH. level is held in its own register (AW+1 bits). empty and full are decoded from level.
- Write accepted when rx_done=1 and (full=0, or rd_en=1 in the same cycle). The byte lands at wr_ptr, wr_ptr increments, and it is visible on rd_data the next cycle if the FIFO was empty.
- Read accepted when rd_en=1 and empty=0. rd_ptr increments. rd_data shows the next entry the following cycle. rd_en while empty is ignored, with no state change.
- Level update in the same cycle: a write alone adds 1, a read alone subtracts 1, both together leave level unchanged.
- Full with rx_done and rd_en together: both are accepted, level stays DEPTH, overrun is not set.
- Empty with rx_done and rd_en together: only the write happens, level becomes 1.
- Overrun: rx_done while full and no read → byte dropped, pointers unchanged, overrun <= 1. ovr_clr clears it next cycle. If a set and ovr_clr coincide, the set wins.
- Flush has priority over everything in its cycle. Pointers and level go to 0, the timeout counter and irq_timeout clear, and any coincident write or read is discarded without setting overrun. The overrun flag is untouched.
- Timeout counter, 16 bits:
  - Reset to 0 on any accepted write, accepted read, or flush.
  - Held at 0 while level==0.
  - Otherwise increments on each b_tick and saturates at TO_TICKS.
  - When it reaches TO_TICKS, irq_timeout <= 1 (registered, one cycle after the terminal tick).
  - irq_timeout clears on an accepted read, an accepted write, flush, or rst.
- irq_thresh is combinational from the registered level and thresh. Values of thresh above DEPTH mean irq_thresh never asserts.
- All outputs except rd_data and irq_thresh are registered. Write-to-level latency is 1 cycle.
- Reset mid-burst: any in-progress rx_done in the reset cycle is dropped.

Test Plan:
1. After reset, send bytes 0x11,0x22,0x33 via rx_done pulses → level=3, rd_data=0x11. Three rd_en cycles → output 0x11,0x22,0x33, then empty=1, level=0.
2. Fill 16 bytes 0x00..0x0F, then send a 17th byte 0xAA → full=1, overrun=1, level=16. Drain → 0x00..0x0F exactly, 0xAA absent. ovr_clr → overrun=0.
3. Full FIFO, rx_done(0x55) and rd_en in the same cycle → level stays 16, overrun=0. The last entry after draining is 0x55.
4. Read/write pointer wrap: loop 40 cycles of a write followed by a read, with incrementing data → every read equals its write, level toggles 0/1, no overrun.
5. thresh=4: write 3 bytes → irq_thresh=0; write a 4th → irq_thresh=1; one read → irq_thresh=0. With thresh=0, irq_thresh stays 0 at level 16.
6. Write 1 byte, then send 160 b_ticks with no activity → irq_timeout=1 after the 160th tick. One read → irq_timeout=0 and counter 0. Flush asserted together with rx_done → level=0 and overrun unchanged.
